// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stage sequencer: FSM state encoding and the
// per-stage enable/clear bundle the pipeline top also consumes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StHold   = 2'd1,
        StFlush  = 2'd2,
        StRefill = 2'd3
    } ps_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    typedef struct packed {
        stage_en_t en;
        logic      if_id_clr;
        logic      id_ex_clr;
        logic      refill;
    } stage_ctl_t;

    localparam stage_en_t EnAll  = stage_en_t'(5'b11111);
    localparam stage_en_t EnNone = stage_en_t'(5'b00000);

    localparam stage_ctl_t CtlReset = '{
        en:        EnNone,
        if_id_clr: 1'b1,
        id_ex_clr: 1'b1,
        refill:    1'b0
    };

    // Stage controls implied by the FSM state alone (no reset/mem-stall override).
    function automatic stage_ctl_t state_ctl(input ps_state_e st);
        stage_ctl_t c;
        c = '{en: EnAll, if_id_clr: 1'b0, id_ex_clr: 1'b0, refill: 1'b0};
        unique case (st)
            StRun: ;
            StHold: begin
                c.en        = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
                c.id_ex_clr = 1'b1;
            end
            StFlush: begin
                c.if_id_clr = 1'b1;
                c.id_ex_clr = 1'b1;
            end
            StRefill: c.refill = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Hazard-resolver inputs and per-stage control outputs of the stage sequencer.
interface pipe_stage_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pc_freeze;
    logic             do_flush;
    logic             resolved;
    logic             mem_stall;
    logic             clr_stats;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_clr;
    logic             id_ex_clr;
    logic             refill;
    logic             timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output pc_freeze, do_flush, resolved, mem_stall, clr_stats,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_clr, id_ex_clr, refill, timeout, stall_cycles, flush_events
    );

    modport slave (
        input  pc_freeze, do_flush, resolved, mem_stall, clr_stats,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_clr, id_ex_clr, refill, timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);
    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage sequencer: maps hazard-resolver requests and data-memory stalls
// onto per-stage load enables/bubble clears, with flush/refill, watchdog and stats.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 15,
    parameter int unsigned REFILL_CYC  = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_ctrl_if.slave bus_io
);
    localparam int unsigned HoldW   = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam int unsigned RefillW = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(STALL_LIMIT - 1);
    localparam logic [RefillW-1:0] RefillLast = RefillW'(REFILL_CYC - 1);

    ps_state_e          state_q, state_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [RefillW-1:0] refill_cnt_q, refill_cnt_d;
    logic               timeout_q, timeout_d;
    logic               wdog_fire;
    stage_ctl_t         ctl;

    // Next state; a memory stall freezes the FSM and both cycle counters.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        refill_cnt_d = refill_cnt_q;
        wdog_fire    = 1'b0;
        if (!bus_io.mem_stall) begin
            unique case (state_q)
                StRun: begin
                    if (bus_io.do_flush) begin
                        state_d = StFlush;
                    end else if (bus_io.pc_freeze) begin
                        state_d    = StHold;
                        hold_cnt_d = '0;
                    end
                end
                StHold: begin
                    if (bus_io.do_flush) begin
                        state_d = StFlush;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_d   = StFlush;
                        wdog_fire = 1'b1;
                    end else if (bus_io.resolved) begin
                        state_d = StRun;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StFlush: begin
                    state_d      = StRefill;
                    refill_cnt_d = '0;
                end
                StRefill: begin
                    if (bus_io.do_flush) begin
                        state_d = StFlush;
                    end else if (refill_cnt_q == RefillLast) begin
                        state_d = StRun;
                    end else begin
                        refill_cnt_d = refill_cnt_q + 1'b1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        timeout_d = timeout_q | wdog_fire;
        if (bus_io.clr_stats) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            hold_cnt_q   <= '0;
            refill_cnt_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            refill_cnt_q <= refill_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Reset and memory stall override the state-derived controls in the same cycle.
    always_comb begin
        ctl = state_ctl(state_q);
        if (rst) begin
            ctl = CtlReset;
        end else if (bus_io.mem_stall) begin
            ctl.en        = EnNone;
            ctl.if_id_clr = 1'b0;
            ctl.id_ex_clr = 1'b0;
        end
    end

    assign bus_io.pc_en     = ctl.en.pc;
    assign bus_io.if_id_en  = ctl.en.if_id;
    assign bus_io.id_ex_en  = ctl.en.id_ex;
    assign bus_io.ex_mem_en = ctl.en.ex_mem;
    assign bus_io.mem_wb_en = ctl.en.mem_wb;
    assign bus_io.if_id_clr = ctl.if_id_clr;
    assign bus_io.id_ex_clr = ctl.id_ex_clr;
    assign bus_io.refill    = ctl.refill;
    assign bus_io.timeout   = timeout_q;

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (~ctl.en.pc),
        .clr_i   (bus_io.clr_stats),
        .count_o (bus_io.stall_cycles)
    );

    sat_counter #(
        .Width (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == StFlush) && !bus_io.mem_stall),
        .clr_i   (bus_io.clr_stats),
        .count_o (bus_io.flush_events)
    );
endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Pipeline stage sequencer between the hazard-resolver FSM and the five pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It turns the resolver's `pc_freeze`/`do_flush`/`resolved` outputs, plus a data-memory stall, into per-stage load enables and bubble clears. It also sequences flush/refill, runs a stall watchdog, and keeps saturating stall/flush statistics.

## Interface
- `STALL_LIMIT`, default 15: consecutive HOLD cycles before the watchdog fires.
- `REFILL_CYC`, default 2: REFILL state length in cycles, ≥1.
- `CNT_W`, default 16: statistics counter width.
- `clk  in  1` — clock.
- `rst  in  1` — reset, synchronous, active-high.
- `pc_freeze  in  1` — hazard resolver requests a front-end stall.
- `do_flush  in  1` — hazard resolver requests a flush (mispredict).
- `resolved  in  1` — hazard resolver is back in normal state.
- `mem_stall  in  1` — data memory not ready; freezes the whole pipeline.
- `clr_stats  in  1` — clears counters and `timeout`.
- `pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each` — stage load enables.
- `if_id_clr, id_ex_clr  out  1 each` — load a bubble (NOP) into that register.
- `refill  out  1` — pipeline refilling after a flush.
- `timeout  out  1` — sticky watchdog flag.
- `stall_cycles  out  CNT_W` — saturating count of cycles with `pc_en`=0.
- `flush_events  out  CNT_W` — saturating count of FLUSH cycles.

## Operation
- States: RUN, HOLD, FLUSH, REFILL. Reset state is RUN. Outputs are combinational from state, `mem_stall` and `rst`.
- While `rst`=1: all enables 0; `if_id_clr`=`id_ex_clr`=1; `refill`=0; counters, `timeout` and the HOLD/REFILL counters cleared.
- `mem_stall`=1 overrides everything:
  - all enables 0, all clears 0;
  - state and the REFILL counter hold;
  - the HOLD run counter neither increments nor triggers the watchdog.
- Input priority within a state: `do_flush` > watchdog > `pc_freeze`/`resolved`.
- RUN:
  - outputs: all enables 1, clears 0;
  - `do_flush` → FLUSH; else `pc_freeze` → HOLD; else stay.
- HOLD:
  - outputs: `pc_en`=`if_id_en`=0; `id_ex_en`=1 with `id_ex_clr`=1; EX/MEM and MEM/WB enables 1;
  - `do_flush` → FLUSH;
  - else run counter = STALL_LIMIT−1 → FLUSH and set `timeout`;
  - else `resolved` → RUN; else stay.
  - Run counter zeroes on HOLD entry.
- FLUSH (exactly 1 cycle):
  - outputs: all enables 1, `if_id_clr`=`id_ex_clr`=1; `pc_en`=1 so the redirect target loads;
  - next state REFILL.
- REFILL:
  - outputs: all enables 1, clears 0, `refill`=1;
  - `do_flush` → FLUSH; else after REFILL_CYC cycles → RUN;
  - `pc_freeze` is ignored in REFILL.
- Statistics counters saturate at all-ones.
- `clr_stats` zeroes both counters and `timeout`. It wins over a same-cycle increment or watchdog set.

## Timing
- Enables and clears respond in the same cycle to `mem_stall` and `rst`; state-driven changes appear one cycle after the sampling edge.
- `do_flush` sampled high in RUN at edge N: FLUSH outputs during cycle N+1, REFILL during N+2..N+1+REFILL_CYC, RUN after.
- `pc_freeze` held with no `resolved`: exactly STALL_LIMIT HOLD cycles (excluding `mem_stall` cycles), then FLUSH, with `timeout`=1 from the FLUSH cycle onward.
- `flush_events` increments once per FLUSH cycle, including back-to-back flushes from REFILL.
- Reset mid-FLUSH or mid-REFILL: RUN on the next edge, no residual `refill`.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (RUN=2'd0, HOLD=2'd1, FLUSH=2'd2, REFILL=2'd3) and the stage-enable bundle struct, reused by the pipeline top.
- Sub-module `sat_counter` (parameter width; inc, clr; saturating), instantiated for `stall_cycles` and `flush_events`.

## Test plan
- Reset released, no hazards: all enables 1, clears 0, `stall_cycles`=`flush_events`=0, `timeout`=0.
- `pc_freeze`=1 for 3 cycles then `resolved`=1: 3 cycles with `pc_en`=0 and `id_ex_clr`=1; `stall_cycles`=3; back to RUN.
- `do_flush` pulse, REFILL_CYC=2: 1 FLUSH cycle with both clears, 2 cycles `refill`=1; `flush_events`=1.
- `pc_freeze` stuck with STALL_LIMIT=15: FLUSH after 15 HOLD cycles, `timeout`=1 sticky; `clr_stats` clears it and both counters.
- `mem_stall` asserted for 4 cycles mid-REFILL: all enables 0, REFILL length still 2 non-stalled cycles, `stall_cycles`+=4.
- `do_flush` during REFILL, plus `rst` during HOLD: re-FLUSH with `flush_events`=2; reset returns to RUN next edge.
